// File: rtl/lsu_axil.sv
// Load/store unit: core memory-stage requests to an AXI4-Lite master port.
// Byte/half/word with strobes, lane steering, extension and misalign traps.
module lsu_axil #(
  parameter int          ADDR_W      = 32,
  parameter logic [2:0]  AXPROT      = 3'b000,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_misalign_o,
  output logic [ADDR_W-1:0] m_axi_awaddr_o,
  output logic [2:0]        m_axi_awprot_o,
  output logic              m_axi_awvalid_o,
  input  logic              m_axi_awready_i,
  output logic [31:0]       m_axi_wdata_o,
  output logic [3:0]        m_axi_wstrb_o,
  output logic              m_axi_wvalid_o,
  input  logic              m_axi_wready_i,
  input  logic [1:0]        m_axi_bresp_i,
  input  logic              m_axi_bvalid_i,
  output logic              m_axi_bready_o,
  output logic [ADDR_W-1:0] m_axi_araddr_o,
  output logic [2:0]        m_axi_arprot_o,
  output logic              m_axi_arvalid_o,
  input  logic              m_axi_arready_i,
  input  logic [31:0]       m_axi_rdata_i,
  input  logic [1:0]        m_axi_rresp_i,
  input  logic              m_axi_rvalid_i,
  output logic              m_axi_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_FAULT
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_q;
  logic              w_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              uns_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_mis_q;

  logic        accept;
  logic        mis;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] lane_sh;
  logic [31:0] load_ext;

  logic unused_ok;
  assign unused_ok = ^{m_axi_bresp_i[0], m_axi_rresp_i[0]};

  assign accept = req_valid_i & req_ready_o;

  always_comb begin
    mis = 1'b0;
    if (ALIGN_CHECK) begin
      mis = (req_size_i == 2'b01 && req_addr_i[0])
         || (req_size_i[1] && req_addr_i[1:0] != 2'b00);
    end
  end

  always_comb begin
    wstrb_n = 4'b1111;
    wdata_n = req_wdata_i;
    unique case (1'b1)
      req_size_i == 2'b00: begin
        wstrb_n = 4'b0001 << req_addr_i[1:0];
        wdata_n = {4{req_wdata_i[7:0]}};
      end
      req_size_i == 2'b01: begin
        wstrb_n = 4'b0011 << {req_addr_i[1], 1'b0};
        wdata_n = {2{req_wdata_i[15:0]}};
      end
      req_size_i[1]: begin
        wstrb_n = 4'b1111;
        wdata_n = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    lane_sh  = m_axi_rdata_i;
    load_ext = m_axi_rdata_i;
    unique case (1'b1)
      size_q == 2'b00: begin
        lane_sh  = m_axi_rdata_i >> {lane_q, 3'b000};
        load_ext = {{24{~uns_q & lane_sh[7]}}, lane_sh[7:0]};
      end
      size_q == 2'b01: begin
        lane_sh  = m_axi_rdata_i >> {lane_q[1], 4'b0000};
        load_ext = {{16{~uns_q & lane_sh[15]}}, lane_sh[15:0]};
      end
      size_q[1]: begin
        lane_sh  = m_axi_rdata_i;
        load_ext = m_axi_rdata_i;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_FAULT: begin
        state_d = S_IDLE;
        if (accept) begin
          unique case (1'b1)
            mis:              state_d = S_FAULT;
            !mis && req_we_i: state_d = S_WR;
            !mis && !req_we_i: state_d = S_RD_ADDR;
          endcase
        end
      end
      S_WR: begin
        if ((!aw_q || m_axi_awready_i) && (!w_q || m_axi_wready_i))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: if (m_axi_bvalid_i) state_d = S_IDLE;
      S_RD_ADDR: if (m_axi_arready_i) state_d = S_RD_DATA;
      S_RD_DATA: if (m_axi_rvalid_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FAULT is the cycle the trap response is visible, so it accepts like IDLE
  always_comb begin
    req_ready_o     = 1'b0;
    m_axi_bready_o  = 1'b0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = 1'b0;
    unique case (state_q)
      S_IDLE, S_FAULT: req_ready_o = 1'b1;
      S_WR_RESP:       m_axi_bready_o = 1'b1;
      S_RD_ADDR:       m_axi_arvalid_o = 1'b1;
      S_RD_DATA:       m_axi_rready_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_q        <= 1'b0;
      w_q         <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
      if (accept) begin
        addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
        size_q <= req_size_i;
        lane_q <= req_addr_i[1:0];
        uns_q  <= req_unsigned_i;
        if (req_we_i) begin
          wdata_q <= wdata_n;
          wstrb_q <= wstrb_n;
        end
        if (mis) begin
          rsp_valid_q <= 1'b1;
          rsp_mis_q   <= 1'b1;
        end else if (req_we_i) begin
          aw_q <= 1'b1;
          w_q  <= 1'b1;
        end
      end
      if (state_q == S_WR) begin
        if (m_axi_awready_i) aw_q <= 1'b0;
        if (m_axi_wready_i)  w_q  <= 1'b0;
      end
      if (state_q == S_WR_RESP && m_axi_bvalid_i) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= m_axi_bresp_i[1];
      end
      if (state_q == S_RD_DATA && m_axi_rvalid_i) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= m_axi_rresp_i[1];
        rsp_rdata_q <= m_axi_rresp_i[1] ? 32'h0 : load_ext;
      end
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign rsp_misalign_o  = rsp_mis_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awprot_o  = AXPROT;
  assign m_axi_awvalid_o = aw_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wvalid_o  = w_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arprot_o  = AXPROT;

endmodule
